collision_judge: RTL
====================

COLLISION_JUDGE -- requirements
Module: collision_judge

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ENEMY_W, 50, enemy sprite width in pixels
- ENEMY_H, 50, enemy sprite height in pixels
- BULLET_W, 4, bullet box width
- BULLET_H, 10, bullet box height
- PLAYER_W, 50, player box width
- PLAYER_H, 50, player box height
- BOOM_TICKS, 16, move_tick count for which boom is held
- LIVES_INIT, 3, lives after reset
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  system clock, the only clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- move_tick  in  1  one-clk enable pulse at the game movement rate
- enemy_x, enemy_y  in  10 each  enemy top-left corner
- enemyplane_exist  in  1  enemy alive and not exploding
- bullet_x, bullet_y  in  10 each  bullet top-left corner
- bullet_valid  in  1  bullet in flight
- player_x, player_y  in  10 each  player top-left corner
- boom  out  1  explosion request to the enemy stage
- bullet_clear  out  1  one-clk pulse that retires the bullet
- player_hit  out  1  one-clk pulse when the enemy rams the player
- score  out  16  4-digit BCD score, digit 3 in [15:12]
- lives  out  2  remaining lives
- game_over  out  1  high when lives == 0

Function
REQ-003 Overlap tests SHALL use 11-bit unsigned sums so that coordinate+size never wraps.
REQ-004 bullet_overlap SHALL be true iff bx<ex+ENEMY_W, bx+BULLET_W>ex, by<ey+ENEMY_H and by+BULLET_H>ey. Edges that only touch SHALL NOT count.
REQ-005 player_overlap SHALL use the same strict rule with PLAYER_W/PLAYER_H against the enemy box.
REQ-006 The FSM SHALL have states ARMED, BOOM, RELEASE and OVER.
REQ-007 ARMED: on any clk with enemyplane_exist=1, bullet_valid=1 and bullet_overlap, the block SHALL go to BOOM on the next edge.
- The same edge SHALL pulse bullet_clear for one clk and increment score by 1.
REQ-008 ARMED: on any clk with enemyplane_exist=1 and player_overlap and no bullet hit, the block SHALL go to BOOM on the next edge.
- The same edge SHALL pulse player_hit for one clk and decrement lives by 1.
- Score SHALL NOT change.
REQ-009 If bullet and player hits occur in the same clk, the bullet hit SHALL take priority and lives SHALL be unchanged.
REQ-010 Detection latency SHALL be exactly one clk: the condition is true in cycle N and the outputs are visible after edge N+1.
REQ-011 BOOM: boom SHALL be 1, and a 5-bit tick counter cleared on entry SHALL increment on each move_tick.
- When the counter reaches BOOM_TICKS, the block SHALL go to RELEASE.
REQ-012 RELEASE: boom SHALL be 0.
- On the first move_tick the block SHALL go to ARMED, so boom is low for at least one full move_tick period.
REQ-013 No hit detection SHALL occur in BOOM, RELEASE or OVER.
REQ-014 Score SHALL be BCD with per-digit carry and SHALL saturate at 16'h9999.
REQ-015 Lives SHALL never go below 0.
- If a player hit takes lives to 0, the block SHALL go to OVER instead of BOOM, with boom=0 and game_over=1.
- OVER SHALL be left only by rst.
REQ-016 If enemyplane_exist falls while in ARMED, no hit SHALL register.
- It SHALL NOT affect the BOOM or RELEASE sequencing.
REQ-017 move_tick SHALL only gate the BOOM and RELEASE timing. Detection runs every clk.

Reset
REQ-018 When rst=1 at an edge, the block SHALL set: state=ARMED, boom=0, bullet_clear=0, player_hit=0, score=16'h0000, lives=LIVES_INIT, game_over=0, tick counter=0.
REQ-019 Reset SHALL override any in-progress BOOM, RELEASE or OVER state in the same edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- enemy (100,100), bullet (120,140), valid=1, exist=1 -> one clk later: boom=1, bullet_clear single pulse, score=0001.
- boom held, 16 move_ticks -> boom falls after the 16th tick, stays 0 for the next tick period, then re-arms.
- bullet (150,100) touching enemy right edge at ex=100 -> no hit.
- bullet and player overlap in the same clk -> score+1, lives stay 3, player_hit=0.
- three separate player hits -> lives 2,1,0; the third gives game_over=1, boom=0, and further overlaps are ignored.
- score preset near 0099 then hit -> 0100; at 9999 a hit keeps 9999.
- rst asserted mid-BOOM -> next clk: boom=0, score=0000, lives=3, ARMED.

Source files
------------

// File: rtl/collision_judge.sv
// Collision judge: detects bullet/enemy and player/enemy box overlap, owns the
// score (4-digit BCD, saturating) and lives, and sequences the enemy explosion
// through ARMED -> BOOM -> RELEASE -> ARMED, or into OVER when lives run out.
module collision_judge #(
  parameter int ENEMY_W    = 50,
  parameter int ENEMY_H    = 50,
  parameter int BULLET_W   = 4,
  parameter int BULLET_H   = 10,
  parameter int PLAYER_W   = 50,
  parameter int PLAYER_H   = 50,
  parameter int BOOM_TICKS = 16,
  parameter int LIVES_INIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_tick,
  input  logic [9:0]  enemy_x,
  input  logic [9:0]  enemy_y,
  input  logic        enemyplane_exist,
  input  logic [9:0]  bullet_x,
  input  logic [9:0]  bullet_y,
  input  logic        bullet_valid,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  output logic        boom,
  output logic        bullet_clear,
  output logic        player_hit,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        game_over
);

  typedef enum logic [1:0] {ARMED, BOOM, RELEASE, OVER} state_t;

  localparam logic [10:0] EW = 11'(ENEMY_W);
  localparam logic [10:0] EH = 11'(ENEMY_H);
  localparam logic [10:0] BW = 11'(BULLET_W);
  localparam logic [10:0] BH = 11'(BULLET_H);
  localparam logic [10:0] PW = 11'(PLAYER_W);
  localparam logic [10:0] PH = 11'(PLAYER_H);
  localparam logic [4:0]  BOOM_LAST  = 5'(BOOM_TICKS);
  localparam logic [1:0]  LIVES_RST  = 2'(LIVES_INIT);

  state_t      state, state_nxt;
  logic [4:0]  tick_cnt;
  logic [10:0] ex, ey, bx, by, px, py;
  logic        bullet_ovl_p0, player_ovl_p0;
  logic        bullet_hit_p0, player_hit_p0;
  logic        bullet_clear_p1, player_hit_p1;
  logic [15:0] score_p1;
  logic [1:0]  lives_p1;

  // BCD increment with per-digit carry; holds at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Lives decrement that stops at zero.
  function automatic logic [1:0] lives_dec_sat(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  assign ex = {1'b0, enemy_x};
  assign ey = {1'b0, enemy_y};
  assign bx = {1'b0, bullet_x};
  assign by = {1'b0, bullet_y};
  assign px = {1'b0, player_x};
  assign py = {1'b0, player_y};

  // ---- stage p0: strict-overlap detection, only while armed ----
  always_comb begin
    bullet_ovl_p0 = (bx < ex + EW) && (bx + BW > ex) && (by < ey + EH) && (by + BH > ey);
    player_ovl_p0 = (px < ex + EW) && (px + PW > ex) && (py < ey + EH) && (py + PH > ey);
    bullet_hit_p0 = (state == ARMED) && enemyplane_exist && bullet_valid && bullet_ovl_p0;
    player_hit_p0 = (state == ARMED) && enemyplane_exist && player_ovl_p0 && !bullet_hit_p0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ARMED;
    else     state <= state_nxt;
  end

  // Next-state logic; the final player hit diverts to OVER instead of BOOM.
  always_comb begin
    state_nxt = state;
    case (state)
      ARMED: begin
        if (bullet_hit_p0)      state_nxt = BOOM;
        else if (player_hit_p0) state_nxt = (lives <= 2'd1) ? OVER : BOOM;
      end
      BOOM:    if (move_tick && (tick_cnt + 5'd1 == BOOM_LAST)) state_nxt = RELEASE;
      RELEASE: if (move_tick) state_nxt = ARMED;
      OVER:    state_nxt = OVER;
      default: state_nxt = ARMED;
    endcase
  end

  // Explosion tick counter: cleared on entry to BOOM, counts move_ticks inside it.
  always_ff @(posedge clk) begin
    if (rst)                                      tick_cnt <= 5'd0;
    else if (state != BOOM && state_nxt == BOOM)  tick_cnt <= 5'd0;
    else if (state == BOOM && move_tick)          tick_cnt <= tick_cnt + 5'd1;
  end

  // ---- stage p1: registered hit pulses, score and lives ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bullet_clear_p1 <= 1'b0;
      player_hit_p1   <= 1'b0;
      score_p1        <= 16'h0000;
      lives_p1        <= LIVES_RST;
    end else begin
      bullet_clear_p1 <= bullet_hit_p0;
      player_hit_p1   <= player_hit_p0;
      if (bullet_hit_p0) score_p1 <= bcd_inc_sat(score_p1);
      if (player_hit_p0) lives_p1 <= lives_dec_sat(lives_p1);
    end
  end

  // State-decoded outputs.
  always_comb begin
    boom      = (state == BOOM);
    game_over = (state == OVER);
  end

  assign bullet_clear = bullet_clear_p1;
  assign player_hit   = player_hit_p1;
  assign score        = score_p1;
  assign lives        = lives_p1;

endmodule
